// File: rtl/spi_master_tx.sv
// SPI mode-0 master: takes a W-bit word over valid/ready, shifts it out MSB-first on mosi
// while capturing miso, and presents the received word with a one-cycle done pulse.
module spi_master_tx #(
  parameter int NUM_BYTES = 4,
  parameter int CLK_DIV   = 2,
  localparam int W   = 8 * NUM_BYTES,
  localparam int BCW = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1,
  localparam int DW  = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic [W-1:0] tx_data_i,
  input  logic         tx_valid_i,
  output logic         tx_ready_o,
  output logic [W-1:0] rx_data_o,
  output logic         done_o,
  output logic         byte_done_o,
  output logic         busy_o,
  output logic         sclk_o,
  output logic         mosi_o,
  input  logic         miso_i,
  output logic         cs_n_o
);

  typedef enum logic [1:0] {IDLE, LOW, HIGH, HOLD} state_e;

  localparam logic [DW-1:0]  DIV_MAX   = DW'(CLK_DIV - 1);
  localparam logic [BCW-1:0] LAST_BYTE = BCW'(NUM_BYTES - 1);

  state_e         state_q, state_d;
  logic [DW-1:0]  div_q, div_d;
  logic [2:0]     bit_q, bit_d;
  logic [BCW-1:0] byte_q, byte_d;
  logic [W-1:0]   txs_q, txs_d;
  logic [W-1:0]   rxs_q, rxs_d;
  logic [W-1:0]   rxd_q, rxd_d;
  logic           done_q, done_d;
  logic           bd_q, bd_d;
  logic           last_bit;

  assign last_bit = (bit_q == 3'd7) && (byte_q == LAST_BYTE);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      txs_q   <= '0;
      rxs_q   <= '0;
      rxd_q   <= '0;
      done_q  <= 1'b0;
      bd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      txs_q   <= txs_d;
      rxs_q   <= rxs_d;
      rxd_q   <= rxd_d;
      done_q  <= done_d;
      bd_q    <= bd_d;
    end
  end

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    byte_d  = byte_q;
    txs_d   = txs_q;
    rxs_d   = rxs_q;
    rxd_d   = rxd_q;
    done_d  = 1'b0;
    bd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (tx_valid_i) begin
          state_d = LOW;
          div_d   = DIV_MAX;
          bit_d   = '0;
          byte_d  = '0;
          txs_d   = tx_data_i;
        end
      end
      LOW: begin
        if (div_q == '0) begin
          state_d = HIGH;
          div_d   = DIV_MAX;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      HIGH: begin
        // Capture on the first cycle after sclk rises; miso has had a full low phase to settle.
        if (div_q == DIV_MAX) rxs_d = {rxs_q[W-2:0], miso_i};
        if (div_q == '0) begin
          div_d = DIV_MAX;
          bit_d = bit_q + 3'd1;
          bd_d  = (bit_q == 3'd7);
          if (bit_q == 3'd7) byte_d = last_bit ? '0 : byte_q + BCW'(1);
          if (last_bit) begin
            state_d = HOLD;
          end else begin
            state_d = LOW;
            txs_d   = {txs_q[W-2:0], 1'b0};
          end
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      HOLD: begin
        if (div_q == '0) begin
          state_d = IDLE;
          done_d  = 1'b1;
          rxd_d   = rxs_q;
        end else begin
          div_d = div_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign tx_ready_o  = (state_q == IDLE);
  assign busy_o      = ~tx_ready_o;
  assign cs_n_o      = (state_q == IDLE);
  assign sclk_o      = (state_q == HIGH);
  assign mosi_o      = txs_q[W-1];
  assign rx_data_o   = rxd_q;
  assign done_o      = done_q;
  assign byte_done_o = bd_q;

endmodule

// File: tb/tb_spi_master_tx.sv
// Scoreboard bench for spi_master_tx: a 4-byte/CLK_DIV=2 instance and a 1-byte/CLK_DIV=1 instance.
module tb_spi_master_tx;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] tx_data = '0;
  logic        tx_valid = 1'b0;
  logic        tx_ready, done, byte_done, busy, sclk, mosi, miso, cs_n;
  logic [31:0] rx_data;
  logic        miso_tie = 1'b0;

  logic [7:0]  tx_data_b = '0;
  logic        tx_valid_b = 1'b0;
  logic        tx_ready_b, done_b, byte_done_b, busy_b, sclk_b, mosi_b, cs_n_b;
  logic [7:0]  rx_data_b;

  always #5 clk = ~clk;

  assign miso = miso_tie ? 1'b1 : mosi;

  spi_master_tx #(.NUM_BYTES(4), .CLK_DIV(2)) u_dut (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data), .tx_valid_i(tx_valid),
    .tx_ready_o(tx_ready), .rx_data_o(rx_data), .done_o(done), .byte_done_o(byte_done),
    .busy_o(busy), .sclk_o(sclk), .mosi_o(mosi), .miso_i(miso), .cs_n_o(cs_n));

  spi_master_tx #(.NUM_BYTES(1), .CLK_DIV(1)) u_dut_b (
    .clk_i(clk), .rst_ni(rst_n), .tx_data_i(tx_data_b), .tx_valid_i(tx_valid_b),
    .tx_ready_o(tx_ready_b), .rx_data_o(rx_data_b), .done_o(done_b), .byte_done_o(byte_done_b),
    .busy_o(busy_b), .sclk_o(sclk_b), .mosi_o(mosi_b), .miso_i(mosi_b), .cs_n_o(cs_n_b));

  int pass_cnt = 0;
  int tot_cnt  = 0;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tot_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  typedef struct {
    logic [31:0] rx;
    logic [31:0] mo;
  } exp_t;

  exp_t        exp_q[$];
  logic [7:0]  exp_b_q[$];

  // Monitor for the 4-byte instance
  int          low_cnt = 0, rises = 0, nbd = 0, high_run = 0, last_high_run = 0, done_total = 0;
  logic [31:0] mosi_cap = '0;
  logic        sclk_prev = 1'b0, cs_prev = 1'b1;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      low_cnt = 0; rises = 0; nbd = 0; mosi_cap = '0;
      sclk_prev = 1'b0; cs_prev = 1'b1; high_run = 0;
    end else begin
      if (!cs_n && cs_prev) begin
        last_high_run = high_run;
        high_run = 0;
      end
      if (cs_n) high_run++;
      if (byte_done) begin
        nbd++;
        check("byte_done_cycle", low_cnt, nbd * 32);
      end
      if (!cs_n) begin
        if (sclk && !sclk_prev) begin
          rises++;
          mosi_cap = {mosi_cap[30:0], mosi};
        end
        low_cnt++;
      end
      if (done) begin
        done_total++;
        if (exp_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_done: rx_data %0h with nothing outstanding", rx_data);
        end else begin
          e = exp_q.pop_front();
          check("rx_data", rx_data, e.rx);
          check("mosi_word", mosi_cap, e.mo);
          check("sclk_rises", rises, 32);
          check("done_latency", low_cnt, 130);
          check("byte_done_count", nbd, 4);
          check("cs_n_at_done", cs_n, 1);
        end
        low_cnt = 0; rises = 0; nbd = 0; mosi_cap = '0;
      end
      sclk_prev = sclk;
      cs_prev = cs_n;
    end
  end

  // Monitor for the 1-byte, CLK_DIV=1 instance
  int   low_b = 0, rises_b = 0, toggle_err = 0;
  logic sclk_b_prev = 1'b0;

  always @(negedge clk) begin
    logic [7:0] eb;
    if (!rst_n) begin
      low_b = 0; rises_b = 0; toggle_err = 0; sclk_b_prev = 1'b0;
    end else begin
      if (!cs_n_b) begin
        if (low_b < 16 && sclk_b !== low_b[0]) toggle_err++;
        if (sclk_b && !sclk_b_prev) rises_b++;
        low_b++;
      end
      if (done_b) begin
        if (exp_b_q.size() == 0) begin
          tot_cnt++;
          $display("FAIL unexpected_done_b: rx_data %0h with nothing outstanding", rx_data_b);
        end else begin
          eb = exp_b_q.pop_front();
          check("b_rx_data", rx_data_b, eb);
          check("b_sclk_rises", rises_b, 8);
          check("b_done_latency", low_b, 17);
          check("b_sclk_toggle_errors", toggle_err, 0);
        end
        low_b = 0; rises_b = 0; toggle_err = 0;
      end
      sclk_b_prev = sclk_b;
    end
  end

  task automatic send(input logic [31:0] d, input logic [31:0] erx, input bit keep);
    int n;
    exp_t e;
    @(negedge clk);
    tx_data = d;
    tx_valid = 1'b1;
    n = 0;
    while (!tx_ready && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("accept_timeout", n < 1000, 1);
    e.rx = erx;
    e.mo = d;
    exp_q.push_back(e);
    @(negedge clk);
    if (!keep) tx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || !tx_ready) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("idle_timeout", n < 2000, 1);
  endtask

  initial begin
    int n;
    int done_before;

    #23;
    check("rst_cs_n", cs_n, 1);
    check("rst_sclk", sclk, 0);
    check("rst_mosi", mosi, 0);
    check("rst_tx_ready", tx_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_byte_done", byte_done, 0);
    check("rst_rx_data", rx_data, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);

    // Loopback word
    send(32'hA5C3_0F81, 32'hA5C3_0F81, 1'b0);
    @(negedge clk);
    check("busy_mid_transfer", busy, 1);
    check("tx_ready_mid_transfer", tx_ready, 0);
    wait_idle();

    // miso tied high, all-zero data
    miso_tie = 1'b1;
    send(32'h0000_0000, 32'hFFFF_FFFF, 1'b0);
    wait_idle();
    miso_tie = 1'b0;
    repeat (4) @(negedge clk);

    // Back-to-back with tx_valid held
    send(32'h0000_0001, 32'h0000_0001, 1'b1);
    send(32'h8000_0000, 32'h8000_0000, 1'b0);
    wait_idle();
    check("cs_n_gap_cycles", last_high_run, 1);
    repeat (4) @(negedge clk);

    // Pulse while busy must be ignored
    done_before = done_total;
    send(32'h1234_5678, 32'h1234_5678, 1'b0);
    repeat (20) @(negedge clk);
    tx_data = 32'hDEAD_BEEF;
    tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    wait_idle();
    repeat (150) @(negedge clk);
    check("ignored_no_extra_done", done_total - done_before, 1);
    check("ignored_cs_n_idle", cs_n, 1);

    // Reset asserted mid-transfer
    done_before = done_total;
    send(32'hF0F0_F0F0, 32'hF0F0_F0F0, 1'b0);
    n = 0;
    while (rises < 13 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    check("mid_reset_reach_bit13", n < 1000, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_cs_n", cs_n, 1);
    check("mid_rst_sclk", sclk, 0);
    check("mid_rst_mosi", mosi, 0);
    check("mid_rst_done", done, 0);
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (200) @(negedge clk);
    check("mid_rst_no_done", done_total - done_before, 0);
    check("mid_rst_tx_ready", tx_ready, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_rx_data", rx_data, 0);

    // CLK_DIV=1, one byte
    @(negedge clk);
    tx_data_b = 8'h3C;
    tx_valid_b = 1'b1;
    n = 0;
    while (!tx_ready_b && n < 100) begin
      @(negedge clk);
      n++;
    end
    exp_b_q.push_back(8'h3C);
    @(negedge clk);
    tx_valid_b = 1'b0;
    n = 0;
    while ((exp_b_q.size() != 0 || !tx_ready_b) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("b_idle_timeout", n < 200, 1);

    repeat (5) @(negedge clk);
    $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
    $finish;
  end

endmodule
